// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the two-requester ALU arbiter.
//   - OP_* : 3-bit op-code set understood by the shared ALU
//   - state_t : arbiter FSM state encoding
//   - CNT_W : width of the settle counter (holds 1..15)
package alu_arb_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arb_grant.sv
// alu_arb_grant: combinational two-way grant selection.
//   valid[1:0] : request valids (bit N = requester N)
//   ptr        : preferred requester when both are valid
//   grant[1:0] : one-hot grant, all zero when nobody is valid
module alu_arb_grant (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // A lone valid requester always wins; the pointer only breaks ties.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   clk, reset (async, active-high)
//   reqN_valid/reqN_ready/reqN_op/reqN_a/reqN_b : requester N handshake + operation
//   alu_op/alu_a/alu_b : registered operation presented to the shared ALU
//   alu_result         : combinational result from the shared ALU
//   rsp_valid/rsp_id/rsp_data/rsp_ready : response handshake
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// left undefined, requester 0 has fixed priority and no pointer exists.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [1:0] valid_s;
  logic [1:0] grant_s;
  logic       ptr_s;
  logic       idle_s;
  logic       accept_s;
  logic       acc_id_s;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  assign ptr_s = ptr_q;
`else
  assign ptr_s = 1'b0;
`endif

  assign valid_s = {req1_valid, req0_valid};

  alu_arb_grant u_grant (
    .valid (valid_s),
    .ptr   (ptr_s),
    .grant (grant_s)
  );

  // Ready is combinational so it is never raised for a requester whose valid
  // is low; it is also held low while reset is asserted.
  assign idle_s     = (state_q == ST_IDLE) & ~reset;
  assign req0_ready = idle_s & grant_s[0];
  assign req1_ready = idle_s & grant_s[1];
  assign accept_s   = idle_s & (grant_s != 2'b00);
  assign acc_id_s   = grant_s[1];

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          alu_op_d = acc_id_s ? req1_op : req0_op;
          alu_a_d  = acc_id_s ? req1_a  : req0_a;
          alu_b_d  = acc_id_s ? req1_b  : req0_b;
          rsp_id_d = acc_id_s;
          cnt_d    = SETTLE_LD;
          state_d  = ST_ISSUE;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          // Prefer the other requester on the next tie.
          ptr_d    = ~acc_id_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Capturing at count 1 makes rsp_valid rise SETTLE_CYCLES edges after accept.
        if (cnt_q <= 4'd1) begin
          rsp_data_d  = alu_result;
          rsp_valid_d = 1'b1;
          cnt_d       = 4'd0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        cnt_d       = 4'd0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      alu_op_q    <= 3'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Emulates the shared
// ALU, drives directed scenarios plus a randomized run checked against a
// transaction-timeline reference model. Honours ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int WIDTH  = 32;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]       req0_op, req1_op, alu_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
  logic             rsp_valid, rsp_id, rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  int checks = 0;
  int errors = 0;
  int last_grant;  // model: requester granted most recently (1 after reset so 0 is preferred)

  alu_arbiter #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_AND:  return a & b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_OR:   return a | b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  // Model grant choice: -1 = nobody.
  function automatic int pick(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      return (last_grant == 0) ? 1 : 0;
`else
      return 0;
`endif
    end else if (v0) return 0;
    else if (v1) return 1;
    else return -1;
  endfunction

  task automatic rand_req(input int id);
    if (id == 0) begin
      req0_op = 3'($urandom_range(0, 7)); req0_a = $urandom; req0_b = $urandom;
    end else begin
      req1_op = 3'($urandom_range(0, 7)); req1_a = $urandom; req1_b = $urandom;
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    last_grant = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rand_req(0); rand_req(1);
    @(posedge clk); @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, alu_op} !== 7'd0)
      $display("FAIL reset_ctrl: got r0=%0b r1=%0b rv=%0b id=%0b op=%0d, expected all 0",
               req0_ready, req1_ready, rsp_valid, rsp_id, alu_op);
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, alu_op} !== 7'd0) errors++;
    checks++;
    if ({rsp_data, alu_a, alu_b} !== {(3*WIDTH){1'b0}}) begin
      errors++;
      $display("FAIL reset_data: got data=%h a=%h b=%h, expected 0", rsp_data, alu_a, alu_b);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req0_op = OP_NOR; req0_a = 32'h0000_FFFF; req0_b = 32'h00FF_00FF; req0_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got r0=%0b r1=%0b, expected 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int j = 0; j <= SETTLE; j++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== (j >= SETTLE) || req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_latency: cycle %0d got rv=%0b r0=%0b, expected rv=%0b r0=0",
                 j, rsp_valid, req0_ready, (j >= SETTLE));
      end
      if (j == 0) begin
        checks++;
        if (alu_op !== OP_NOR || alu_a !== 32'h0000_FFFF || alu_b !== 32'h00FF_00FF) begin
          errors++;
          $display("FAIL single_alu: got op=%0d a=%h b=%h, expected op=%0d a=0000ffff b=00ff00ff",
                   alu_op, alu_a, alu_b, OP_NOR);
        end
      end
      if (j < SETTLE) begin @(posedge clk); #1; end
    end
    checks++;
    if (rsp_id !== 1'b0 || rsp_data !== 32'hFF00_0000) begin
      errors++;
      $display("FAIL single_rsp: got id=%0b data=%h, expected id=0 data=ff000000", rsp_id, rsp_data);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got rv=%0b, expected 0", rsp_valid);
    end
  endtask

  task automatic test_contention();
    int exp_seq[4];
    int id, n;
    logic [WIDTH-1:0] exp_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    do_reset();
    rsp_ready = 1'b1; rand_req(0); rand_req(1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      id = -1; n = 0;
      @(negedge clk);
      while (!req0_ready && !req1_ready && n < 20) begin
        @(posedge clk); #1; @(negedge clk); n++;
      end
      if (req0_ready) id = 0; else if (req1_ready) id = 1;
      checks++;
      if (id != exp_seq[t]) begin
        errors++;
        $display("FAIL contention_grant: txn %0d got %0d, expected %0d", t, id, exp_seq[t]);
      end
      if (id < 0) return;
      exp_d = (id == 1) ? alu_fn(req1_op, req1_a, req1_b) : alu_fn(req0_op, req0_a, req0_b);
      @(posedge clk); #1;
      rand_req(id);
      n = 0;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && n < 20) begin
        @(posedge clk); #1; @(negedge clk); n++;
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== id[0] || rsp_data !== exp_d) begin
        errors++;
        $display("FAIL contention_rsp: txn %0d got rv=%0b id=%0b data=%h, expected 1 %0d %h",
                 t, rsp_valid, rsp_id, rsp_data, id, exp_d);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [2:0] e_op; logic [WIDTH-1:0] e_a, e_b, e_d;
    int n;
    do_reset();
    rand_req(1); req1_valid = 1'b1;
    e_op = req1_op; e_a = req1_a; e_b = req1_b; e_d = alu_fn(req1_op, req1_a, req1_b);
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_grant: got r0=%0b r1=%0b, expected 0 1", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    rand_req(0); rand_req(1); req0_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; @(negedge clk); n++;
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin @(posedge clk); #1; rsp_ready = 1'b1; @(negedge clk); end
      else if (k > 0) begin @(posedge clk); #1; @(negedge clk); end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== e_d ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
          alu_op !== e_op || alu_a !== e_a || alu_b !== e_b) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got rv=%0b id=%0b data=%h r=%0b%0b op=%0d a=%h b=%h, expected 1 1 %h 00 %0d %h %h",
                 k, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, alu_op, alu_a, alu_b,
                 e_d, e_op, e_a, e_b);
      end
    end
    @(posedge clk); #1; rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_next: got rv=%0b r0=%0b r1=%0b, expected 0 1 0", rsp_valid, req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_issue();
    logic [WIDTH-1:0] e_d;
    int n;
    do_reset();
    rand_req(0); req0_valid = 1'b1;
    @(posedge clk); #1; req0_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, alu_op} !== 7'd0 ||
        {rsp_data, alu_a, alu_b} !== {(3*WIDTH){1'b0}}) begin
      errors++;
      $display("FAIL midreset_async: got rv=%0b op=%0d a=%h b=%h data=%h, expected all 0",
               rsp_valid, alu_op, alu_a, alu_b, rsp_data);
    end
    @(posedge clk); #1; reset = 1'b0; last_grant = 1;
    rsp_ready = 1'b1;
    for (int k = 0; k < SETTLE + 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_norsp: cycle %0d got rv=%0b, expected 0", k, rsp_valid);
      end
      @(posedge clk); #1;
    end
    rand_req(1); req1_valid = 1'b1; e_d = alu_fn(req1_op, req1_a, req1_b);
    @(posedge clk); #1; req1_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; @(negedge clk); n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== e_d) begin
      errors++;
      $display("FAIL midreset_after: got rv=%0b id=%0b data=%h, expected 1 1 %h", rsp_valid, rsp_id, rsp_data, e_d);
    end
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_withdrawn();
    int n_rsp, n_bad;
    do_reset();
    rsp_ready = 1'b1;
    rand_req(0); rand_req(1); req0_valid = 1'b1;
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL withdrawn_ready: got r1=%0b, expected 0", req1_ready);
    end
    @(posedge clk); #1; req1_valid = 1'b0;
    n_rsp = 0; n_bad = 0;
    for (int k = 0; k < SETTLE + 6; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        n_rsp++;
        if (rsp_id !== 1'b0) n_bad++;
      end
      if (req1_ready !== 1'b0) n_bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_rsp != 1 || n_bad != 0) begin
      errors++;
      $display("FAIL withdrawn_rsp: got %0d responses %0d bad, expected 1 response 0 bad", n_rsp, n_bad);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic busy; int acc_edge, g; logic cur_id; logic ev;
    logic [WIDTH-1:0] e_d, e_a, e_b; logic [2:0] e_op;
    do_reset();
    busy = 1'b0; acc_edge = 0; cur_id = 1'b0;
    e_d = '0; e_a = '0; e_b = '0; e_op = 3'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      rand_req(0); rand_req(1);
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      g = busy ? -1 : pick(req0_valid, req1_valid);
      ev = busy && (cyc >= acc_edge + SETTLE);
      checks++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        errors++;
        $display("FAIL rand_ready: cycle %0d got r0=%0b r1=%0b, expected grant %0d", cyc, req0_ready, req1_ready, g);
      end
      checks++;
      if (rsp_valid !== ev || (ev && (rsp_id !== cur_id || rsp_data !== e_d))) begin
        errors++;
        $display("FAIL rand_rsp: cycle %0d got rv=%0b id=%0b data=%h, expected rv=%0b id=%0b data=%h",
                 cyc, rsp_valid, rsp_id, rsp_data, ev, cur_id, e_d);
      end
      checks++;
      if (alu_op !== e_op || alu_a !== e_a || alu_b !== e_b) begin
        errors++;
        $display("FAIL rand_alu: cycle %0d got op=%0d a=%h b=%h, expected %0d %h %h",
                 cyc, alu_op, alu_a, alu_b, e_op, e_a, e_b);
      end
      if (g >= 0) begin
        busy = 1'b1; acc_edge = cyc + 1; cur_id = g[0]; last_grant = g;
        e_op = (g == 1) ? req1_op : req0_op;
        e_a  = (g == 1) ? req1_a  : req0_a;
        e_b  = (g == 1) ? req1_b  : req0_b;
        e_d  = alu_fn(e_op, e_a, e_b);
      end else if (ev && rsp_ready) begin
        busy = 1'b0;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_op = 3'd0; req1_op = 3'd0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    last_grant = 1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid_issue();
    test_withdrawn();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
